delay_tile_sched_ctrl: RTL
==========================

Name: delay_tile_sched_ctrl

Overview:
Statically scheduled controller that sequences one SRAM-backed delay-line memory tile.
- Generates write and read strobes plus circular addresses so that a stream of cfg_extent words, written one per cycle, reappears exactly cfg_delay cycles later.
- Sits beside the memtile wrapper and replaces fixed per-instance address-generator constants with runtime-loaded start address, delay and extent.
- Reports completion and configuration errors.

Parameters:
ADDR_W, 9, SRAM address width
DEPTH, 512, SRAM word count (power of two, equal to 2**ADDR_W)
CNT_W, 16, width of the delay, extent and cycle counters

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
flush  in  1  synchronous abort; returns to IDLE with no done pulse
cfg_en  in  1  loads cfg_* registers; honoured only in IDLE
cfg_start_addr  in  ADDR_W  base SRAM address
cfg_delay  in  CNT_W  read-after-write delay D in cycles
cfg_extent  in  CNT_W  number of words N
start  in  1  launches a run; honoured only in IDLE
wen  out  1  SRAM write strobe
waddr  out  ADDR_W  SRAM write address
ren  out  1  SRAM read strobe
raddr  out  ADDR_W  SRAM read address
out_valid  out  1  read data valid (ren delayed by 1 cycle)
busy  out  1  high in RUN and DRAIN
done  out  1  one-cycle pulse at end of run
cfg_err  out  1  sticky; set on a rejected start

Behaviour:
Reset:
- All outputs are 0 on the cycle after rst is sampled high.
- State IDLE; counters 0; cfg registers 0.
- rst mid-run aborts immediately.

States: IDLE, RUN, DRAIN, DONE.

IDLE:
- cfg_en latches cfg_*.
- start with legal config → RUN on the next cycle, t=0.
- Legal config: 1 <= D <= DEPTH-1 and N >= 1.
- start with illegal config → stay IDLE; cfg_err set, held until rst or the next legal start.
- start and cfg_en in the same cycle: config is latched first; start uses the new values.

RUN (cycle counter t increments each cycle):
- wen = (t < N); waddr = (start + t) mod DEPTH.
- ren = (t >= D) && (t < D+N); raddr = (start + t - D) mod DEPTH.
- Address sums are computed in CNT_W+1 bits, then truncated to ADDR_W. Wrap at DEPTH is the natural result.
- wen and ren may be high together. Their addresses never collide because D < DEPTH.
- When t == D+N-1 (last read issued) → DRAIN.

DRAIN:
- One cycle; out_valid is high for the last word. → DONE.

DONE:
- done=1 for one cycle, busy=0 → IDLE.

Common rules:
- out_valid is ren registered by one cycle, in every state.
- start or cfg_en while busy: ignored, no error.
- flush in any state: next cycle is IDLE with wen, ren, out_valid and busy at 0. No done pulse. cfg registers are kept. flush has priority over start.
- Total run length is D+N+2 cycles from the start sample to the done pulse.

Optional Feature:
Macro: DELAY_SCHED_STALL_EN.
- When defined: adds input port stall (1 bit).
  - While stall=1 in RUN, t is frozen; wen=0, ren=0.
  - out_valid still reflects the previous cycle's ren.
  - The D-cycle spacing holds in schedule time, not wall time.
  - stall is ignored in IDLE, DRAIN and DONE.
- When undefined: no stall port; RUN advances every cycle.

Test Plan:
1. start=5, D=3, N=4, start pulse:
   - wen on t=0..3 with waddr 5,6,7,8.
   - ren on t=3..6 with raddr 5,6,7,8.
   - out_valid on t=4..7; done 2 cycles after the last ren; busy low with done.
2. Wrap: start=510, D=2, N=4:
   - waddr 510,511,0,1; raddr same sequence offset by 2 cycles.
   - No write address equals a same-cycle read address.
3. Illegal config D=0, then D=512, each with start:
   - Stays IDLE, wen/ren never assert, cfg_err=1.
   - A following legal start (D=1, N=1) clears cfg_err and completes.
4. flush at t=2 of run D=4, N=8:
   - Next cycle IDLE; wen/ren/busy=0; no done.
   - Immediate restart with unchanged config reproduces the full sequence from waddr=start.
5. start and cfg_en asserted while busy (D=10, N=3):
   - Run completes with original values; done after 15 cycles; cfg_err unchanged.
6. With DELAY_SCHED_STALL_EN, D=2, N=3, stall high for 2 cycles at t=1:
   - wen/ren suppressed during the stall.
   - Address sequence is unchanged; done arrives 2 cycles later than without stall.

Source files
------------

// File: rtl/delay_tile_sched_ctrl_if.sv
// Control, configuration and SRAM strobe/address bundle of the delay-tile scheduler.
// The stall member exists only when DELAY_SCHED_STALL_EN is defined.
interface delay_tile_sched_ctrl_if #(
    parameter int unsigned ADDR_W = 9,
    parameter int unsigned CNT_W  = 16
);
    logic              flush;
    logic              cfg_en;
    logic [ADDR_W-1:0] cfg_start_addr;
    logic [CNT_W-1:0]  cfg_delay;
    logic [CNT_W-1:0]  cfg_extent;
    logic              start;
`ifdef DELAY_SCHED_STALL_EN
    logic              stall;
`endif
    logic              wen;
    logic [ADDR_W-1:0] waddr;
    logic              ren;
    logic [ADDR_W-1:0] raddr;
    logic              out_valid;
    logic              busy;
    logic              done;
    logic              cfg_err;

    modport master (
`ifdef DELAY_SCHED_STALL_EN
        output stall,
`endif
        output flush, cfg_en, cfg_start_addr, cfg_delay, cfg_extent, start,
        input  wen, waddr, ren, raddr, out_valid, busy, done, cfg_err
    );

    modport slave (
`ifdef DELAY_SCHED_STALL_EN
        input  stall,
`endif
        input  flush, cfg_en, cfg_start_addr, cfg_delay, cfg_extent, start,
        output wen, waddr, ren, raddr, out_valid, busy, done, cfg_err
    );
endinterface

// File: rtl/delay_tile_sched_ctrl.sv
// Static scheduler for one SRAM delay-line tile: writes N words from a runtime base
// address and reads each back D cycles later. Optional stall: DELAY_SCHED_STALL_EN.
module delay_tile_sched_ctrl #(
    parameter int unsigned ADDR_W = 9,
    parameter int unsigned DEPTH  = 512,
    parameter int unsigned CNT_W  = 16
) (
    input logic                    clk,
    input logic                    rst,
    delay_tile_sched_ctrl_if.slave bus
);
    localparam int unsigned T_W = CNT_W + 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t            state;
    logic [ADDR_W-1:0] start_q;
    logic [CNT_W-1:0]  delay_q;
    logic [CNT_W-1:0]  extent_q;
    logic [T_W-1:0]    t_q;

    logic              wen_q;
    logic [ADDR_W-1:0] waddr_q;
    logic              ren_q;
    logic [ADDR_W-1:0] raddr_q;
    logic              out_valid_q;
    logic              busy_q;
    logic              done_q;
    logic              cfg_err_q;

    // A same-cycle cfg_en overrides the stored config for the start decision
    logic [ADDR_W-1:0] eff_start;
    logic [CNT_W-1:0]  eff_delay;
    logic [CNT_W-1:0]  eff_extent;
    logic              cfg_legal;

    assign eff_start  = bus.cfg_en ? bus.cfg_start_addr : start_q;
    assign eff_delay  = bus.cfg_en ? bus.cfg_delay      : delay_q;
    assign eff_extent = bus.cfg_en ? bus.cfg_extent     : extent_q;
    assign cfg_legal  = (eff_delay != '0) && (eff_delay <= CNT_W'(DEPTH - 1)) &&
                        (eff_extent != '0);

    // t_q is the next schedule slot to issue; slot 0 is issued on the start edge
    logic [T_W-1:0]    d_w;
    logic [T_W-1:0]    n_w;
    logic [T_W-1:0]    end_w;
    logic              slot_wen;
    logic              slot_ren;
    logic [ADDR_W-1:0] slot_waddr;
    logic [ADDR_W-1:0] slot_raddr;

    assign d_w        = T_W'(delay_q);
    assign n_w        = T_W'(extent_q);
    assign end_w      = d_w + n_w;
    assign slot_wen   = (t_q < n_w);
    assign slot_ren   = (t_q >= d_w) && (t_q < end_w);
    assign slot_waddr = ADDR_W'(T_W'(start_q) + t_q);
    assign slot_raddr = ADDR_W'(T_W'(start_q) + t_q - d_w);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            start_q     <= '0;
            delay_q     <= '0;
            extent_q    <= '0;
            t_q         <= '0;
            wen_q       <= 1'b0;
            waddr_q     <= '0;
            ren_q       <= 1'b0;
            raddr_q     <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            cfg_err_q   <= 1'b0;
        end else begin
            out_valid_q <= ren_q;
            done_q      <= 1'b0;
            if (bus.flush) begin
                state       <= IDLE;
                t_q         <= '0;
                wen_q       <= 1'b0;
                ren_q       <= 1'b0;
                out_valid_q <= 1'b0;
                busy_q      <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        wen_q  <= 1'b0;
                        ren_q  <= 1'b0;
                        busy_q <= 1'b0;
                        if (bus.cfg_en) begin
                            start_q  <= bus.cfg_start_addr;
                            delay_q  <= bus.cfg_delay;
                            extent_q <= bus.cfg_extent;
                        end
                        if (bus.start) begin
                            if (cfg_legal) begin
                                // D >= 1, so slot 0 is always a write and never a read
                                state     <= RUN;
                                busy_q    <= 1'b1;
                                wen_q     <= 1'b1;
                                waddr_q   <= eff_start;
                                t_q       <= T_W'(1);
                                cfg_err_q <= 1'b0;
                            end else begin
                                cfg_err_q <= 1'b1;
                            end
                        end
                    end
                    RUN: begin
`ifdef DELAY_SCHED_STALL_EN
                        if (bus.stall) begin
                            wen_q <= 1'b0;
                            ren_q <= 1'b0;
                        end else
`endif
                        if (t_q == end_w) begin
                            state <= DRAIN;
                            wen_q <= 1'b0;
                            ren_q <= 1'b0;
                        end else begin
                            wen_q   <= slot_wen;
                            waddr_q <= slot_waddr;
                            ren_q   <= slot_ren;
                            raddr_q <= slot_raddr;
                            t_q     <= t_q + T_W'(1);
                        end
                    end
                    DRAIN: begin
                        state  <= DONE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        t_q    <= '0;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.wen       = wen_q;
    assign bus.waddr     = waddr_q;
    assign bus.ren       = ren_q;
    assign bus.raddr     = raddr_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.cfg_err   = cfg_err_q;
endmodule
